sd_emmc_ddr_rx_ctrl: RTL and testbench
======================================

# sd_emmc_ddr_rx_ctrl

Receive sequencer for the eMMC host's 8-bit DDR read data path. It consumes the rising-edge and falling-edge byte pairs produced by the DDR input capture stage and finds the start bit. It then streams the block payload out as 16-bit words, checks the per-line, per-edge CRC16 and the end bit, and reports completion or error status to the transfer engine.

## Interface
Parameters:
- TO_W, 24, width of the start-bit timeout counter.

Ports (one clock; reset is asynchronous and active-low):
- clock  in  1  core/card clock, same clock as the DDR capture stage
- reset_n  in  1  async active-low reset
- start  in  1  one-cycle pulse, arms a block receive; accepted only in IDLE
- abort  in  1  one-cycle pulse, returns to IDLE from any state, no done pulse
- block_len  in  10  payload bytes, even, 2..512
- timeout_cycles  in  TO_W  cycles to wait for the start bit; 0 disables the timeout
- iddr_q1  in  8  DAT[7:0] sampled on the rising edge
- iddr_q2  in  8  DAT[7:0] sampled on the falling edge that follows the iddr_q1 sample
- out_data  out  16  {falling byte, rising byte}; the rising byte is first in stream order
- out_valid  out  1  out_data valid, one cycle per word, no backpressure
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at block end, with the err_* flags valid
- err_crc  out  1  CRC mismatch on any line or edge
- err_end  out  1  end bit not all-ones
- err_timeout  out  1  start bit not seen within timeout_cycles
- err_param  out  1  block_len odd, 0, or >512 at start

## Operation
- States: IDLE, WAIT_START, DATA, CRC, END.
- IDLE: start with a valid block_len goes to WAIT_START. Load word_cnt = block_len/2, clear the CRC engines and err_*, and load the timeout counter.
- IDLE: start with an invalid block_len stays in IDLE and pulses done with err_param=1 in the next cycle.
- WAIT_START: iddr_q1 == 8'h00 goes to DATA; iddr_q2 of that cycle is ignored. Otherwise the timeout decrements. On reaching 0 with a nonzero timeout_cycles: done with err_timeout=1, then IDLE.
- DATA: each cycle out_valid=1 and out_data={iddr_q2,iddr_q1}. Line i's rising bit feeds CRC engine R[i]; its falling bit feeds F[i]. word_cnt decrements; after the last word go to CRC.
- CRC: 16 cycles. iddr_q1[i] / iddr_q2[i] carry R[i] / F[i] received CRC bits, MSB first. The engines shift them in; the final remainder must be zero. Then go to END.
- END: iddr_q1 != 8'hFF sets err_end. Pulse done and go to IDLE.
- CRC16 polynomial x^16+x^12+x^5+1, initial value 0.
- abort has priority over every other transition. It clears out_valid immediately and leaves err_* unchanged.
- start while busy is ignored.

## Timing
- Reset values: out_data=0, out_valid=0, busy=0, done=0, all err_*=0, state=IDLE.
- All outputs are registered. out_valid for the pair sampled in cycle k asserts in cycle k+1.
- Start bit in cycle k: the first word is captured in cycle k+1 and driven in cycle k+2.
- Payload of N bytes: N/2 consecutive out_valid cycles with no gaps.
- done follows the end-bit cycle by exactly 1 cycle.
- err_* hold until the next accepted start.
- Boundaries:
  - block_len=2 gives one DATA cycle.
  - block_len=512 exercises the full word_cnt.
  - timeout_cycles=1 times out on the first non-start cycle.
  - start and abort in the same cycle: abort wins.
- reset_n asserted mid-block returns all state and outputs to their reset values asynchronously.

## Configuration
- SD_EMMC_DDR_RX_CRC_EN defined: 16 CRC engines instantiated and err_crc computed as above.
- SD_EMMC_DDR_RX_CRC_EN undefined: no engines; CRC state still lasts 16 cycles with bits discarded; err_crc tied 0.

## Structure
- Shared package sd_emmc_pkg holds:
  - the state enum
  - CRC16 polynomial constant 16'h1021
  - MAX_BLOCK_BYTES=512
  - CRC_BITS=16
- One sub-module, sd_emmc_crc16: serial 1-bit-per-clock CRC16 with clear, enable and data inputs and a 16-bit remainder output. Instantiated 16 times (8 lines × 2 edges) under the macro.

## Test plan
- block_len=4, start bit after 3 idle cycles, payload bytes 11,22,33,44, correct CRCs, end 8'hFF:
  - out_data 16'h2211 then 16'h4433 on consecutive cycles
  - done with no errors
- Same block with bit 3 of falling byte 22 flipped:
  - payload is streamed unchanged
  - done with err_crc=1 (macro on) / err_crc=0 (macro off)
- timeout_cycles=5, no start bit: done with err_timeout=1 exactly 5 cycles after WAIT_START entry; busy drops the next cycle.
- End byte 8'hFE after a correct block: done with err_end=1, err_crc=0.
- block_len=3: no WAIT_START, done+err_param next cycle. block_len=512 random data: 256 words, CRC clean.
- abort 10 words into a 512-byte block, then reset_n pulse mid-block on a second run:
  - immediate IDLE, out_valid=0, no done
  - a following start works normally

Source files
------------

// File: rtl/sd_emmc_pkg.sv
// Shared types and constants for the eMMC 8-bit DDR read-data receive path.
package sd_emmc_pkg;

  localparam int unsigned STATE_W         = 3;
  localparam int unsigned LEN_W           = 10;
  localparam int unsigned WCNT_W          = 9;
  localparam int unsigned DAT_LINES       = 8;
  localparam int unsigned MAX_BLOCK_BYTES = 512;
  localparam int unsigned CRC_BITS        = 16;
  localparam int unsigned CRC_CNT_W       = $clog2(CRC_BITS);
  localparam logic [CRC_BITS-1:0] CRC16_POLY = 16'h1021;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_WAIT  = 3'd1;
  localparam state_t ST_DATA  = 3'd2;
  localparam state_t ST_CRC   = 3'd3;
  localparam state_t ST_END   = 3'd4;

  // Block length must be nonzero, even and no larger than one block.
  function automatic logic len_ok(input logic [LEN_W-1:0] len);
    return (len != '0) && !len[0] && (len <= LEN_W'(MAX_BLOCK_BYTES));
  endfunction

  // One serial CRC16 step, MSB-first, x^16+x^12+x^5+1.
  function automatic logic [CRC_BITS-1:0] crc16_step(input logic [CRC_BITS-1:0] crc,
                                                     input logic d);
    logic fb;
    fb = crc[CRC_BITS-1] ^ d;
    return {crc[CRC_BITS-2:0], 1'b0} ^ (fb ? CRC16_POLY : '0);
  endfunction

endpackage

// File: rtl/sd_emmc_crc16.sv
// Serial 1-bit-per-clock CRC16 engine for one DAT line on one clock edge.
module sd_emmc_crc16
  import sd_emmc_pkg::*;
(
  input  logic                clock,
  input  logic                reset_n,
  input  logic                clear,
  input  logic                enable,
  input  logic                data,
  output logic [CRC_BITS-1:0] remainder
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)    remainder <= '0;
    else if (clear)  remainder <= '0;
    else if (enable) remainder <= crc16_step(remainder, data);
  end

endmodule

// File: rtl/sd_emmc_ddr_rx_ctrl.sv
// eMMC 8-bit DDR receive sequencer: start-bit search, payload streaming, CRC16 and end-bit check.
// Per-line CRC engines are built only when SD_EMMC_DDR_RX_CRC_EN is defined.
module sd_emmc_ddr_rx_ctrl
  import sd_emmc_pkg::*;
#(
  parameter int unsigned TO_W = 24
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] block_len,
  input  logic [TO_W-1:0]  timeout_cycles,
  input  logic [7:0]       iddr_q1,
  input  logic [7:0]       iddr_q2,
  output logic [15:0]      out_data,
  output logic             out_valid,
  output logic             busy,
  output logic             done,
  output logic             err_crc,
  output logic             err_end,
  output logic             err_timeout,
  output logic             err_param
);

  state_t                state, state_n;
  logic [WCNT_W-1:0]     word_cnt, word_cnt_n;
  logic [TO_W-1:0]       to_cnt, to_cnt_n;
  logic                  to_en, to_en_n;
  logic [CRC_CNT_W-1:0]  bit_cnt, bit_cnt_n;
  logic [15:0]           out_data_n;
  logic                  out_valid_n, busy_n, done_n;
  logic                  err_crc_n, err_end_n, err_timeout_n, err_param_n;
  logic                  crc_bad_c;

`ifdef SD_EMMC_DDR_RX_CRC_EN
  logic                crc_clear_c, crc_en_c;
  logic [CRC_BITS-1:0] rem_r [DAT_LINES];
  logic [CRC_BITS-1:0] rem_f [DAT_LINES];

  assign crc_clear_c = (state == ST_IDLE) && start && !abort;
  assign crc_en_c    = (state == ST_DATA) || (state == ST_CRC);

  // Rising-edge bits feed R[i], falling-edge bits feed F[i]; received CRC bits follow the payload.
  for (genvar i = 0; i < int'(DAT_LINES); i++) begin : g_line
    sd_emmc_crc16 u_crc_r (
      .clock(clock), .reset_n(reset_n), .clear(crc_clear_c), .enable(crc_en_c),
      .data(iddr_q1[i]), .remainder(rem_r[i])
    );
    sd_emmc_crc16 u_crc_f (
      .clock(clock), .reset_n(reset_n), .clear(crc_clear_c), .enable(crc_en_c),
      .data(iddr_q2[i]), .remainder(rem_f[i])
    );
  end

  always_comb begin
    crc_bad_c = 1'b0;
    for (int i = 0; i < int'(DAT_LINES); i++) begin
      crc_bad_c = crc_bad_c | (rem_r[i] != '0) | (rem_f[i] != '0);
    end
  end
`else
  assign crc_bad_c = 1'b0;
`endif

  // Next-state and next-output logic; abort overrides every transition.
  always_comb begin
    state_n       = state;
    word_cnt_n    = word_cnt;
    to_cnt_n      = to_cnt;
    to_en_n       = to_en;
    bit_cnt_n     = bit_cnt;
    out_data_n    = out_data;
    out_valid_n   = 1'b0;
    busy_n        = 1'b0;
    done_n        = 1'b0;
    err_crc_n     = err_crc;
    err_end_n     = err_end;
    err_timeout_n = err_timeout;
    err_param_n   = err_param;

    if (abort) begin
      state_n = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            err_crc_n     = 1'b0;
            err_end_n     = 1'b0;
            err_timeout_n = 1'b0;
            if (len_ok(block_len)) begin
              err_param_n = 1'b0;
              state_n     = ST_WAIT;
              word_cnt_n  = block_len[LEN_W-1:1];
              to_cnt_n    = timeout_cycles;
              to_en_n     = (timeout_cycles != '0);
            end else begin
              err_param_n = 1'b1;
              done_n      = 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (iddr_q1 == 8'h00) begin
            state_n = ST_DATA;
          end else if (to_en) begin
            if (to_cnt == TO_W'(1)) begin
              err_timeout_n = 1'b1;
              done_n        = 1'b1;
              state_n       = ST_IDLE;
            end else begin
              to_cnt_n = to_cnt - TO_W'(1);
            end
          end
        end
        ST_DATA: begin
          out_valid_n = 1'b1;
          out_data_n  = {iddr_q2, iddr_q1};
          word_cnt_n  = word_cnt - WCNT_W'(1);
          if (word_cnt == WCNT_W'(1)) begin
            state_n   = ST_CRC;
            bit_cnt_n = '0;
          end
        end
        ST_CRC: begin
          bit_cnt_n = bit_cnt + CRC_CNT_W'(1);
          if (bit_cnt == CRC_CNT_W'(CRC_BITS - 1)) state_n = ST_END;
        end
        ST_END: begin
          err_end_n = (iddr_q1 != 8'hFF);
          err_crc_n = crc_bad_c;
          done_n    = 1'b1;
          state_n   = ST_IDLE;
        end
        default: state_n = ST_IDLE;
      endcase
    end

    busy_n = (state_n != ST_IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      word_cnt    <= '0;
      to_cnt      <= '0;
      to_en       <= 1'b0;
      bit_cnt     <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_crc     <= 1'b0;
      err_end     <= 1'b0;
      err_timeout <= 1'b0;
      err_param   <= 1'b0;
    end else begin
      state       <= state_n;
      word_cnt    <= word_cnt_n;
      to_cnt      <= to_cnt_n;
      to_en       <= to_en_n;
      bit_cnt     <= bit_cnt_n;
      out_data    <= out_data_n;
      out_valid   <= out_valid_n;
      busy        <= busy_n;
      done        <= done_n;
      err_crc     <= err_crc_n;
      err_end     <= err_end_n;
      err_timeout <= err_timeout_n;
      err_param   <= err_param_n;
    end
  end

endmodule

// File: tb/tb_sd_emmc_ddr_rx_ctrl.sv
// Bench for sd_emmc_ddr_rx_ctrl: a transaction-level model builds per-cycle stimulus and expected outputs.
module tb_sd_emmc_ddr_rx_ctrl;

  localparam int MAXC = 8192;
`ifdef SD_EMMC_DDR_RX_CRC_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start, abort;
  logic [9:0]  block_len;
  logic [23:0] timeout_cycles;
  logic [7:0]  iddr_q1, iddr_q2;
  logic [15:0] out_data;
  logic        out_valid, busy, done, err_crc, err_end, err_timeout, err_param;

  always #5 clock = ~clock;

  sd_emmc_ddr_rx_ctrl #(.TO_W(24)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
    .block_len(block_len), .timeout_cycles(timeout_cycles),
    .iddr_q1(iddr_q1), .iddr_q2(iddr_q2), .out_data(out_data), .out_valid(out_valid),
    .busy(busy), .done(done), .err_crc(err_crc), .err_end(err_end),
    .err_timeout(err_timeout), .err_param(err_param)
  );

  int total = 0;
  int bad   = 0;

  // Per-cycle plan: s_* drive cycle n, e_* are the outputs visible during cycle n.
  logic        s_start [MAXC];
  logic        s_abort [MAXC];
  logic        s_rst   [MAXC];
  logic [7:0]  s_q1    [MAXC];
  logic [7:0]  s_q2    [MAXC];
  logic [9:0]  s_len   [MAXC];
  logic [23:0] s_to    [MAXC];
  logic        e_valid [MAXC];
  logic        e_busy  [MAXC];
  logic        e_done  [MAXC];
  logic [15:0] e_data  [MAXC];
  logic [3:0]  e_err   [MAXC];  // {param, timeout, end, crc}

  int          p = 0;
  logic [3:0]  m_err = 4'b0;
  logic [9:0]  cur_len = 10'd2;
  logic [23:0] cur_to = 24'd0;
  logic [7:0]  pay [512];
  bit          cbuf [4096];
  int          clen;
  int          g_start_p, g_word_p;

  int          npin = 0;
  int          pin_c [8];
  int          pin_k [8];
  logic [15:0] pin_v [8];

  int cur = 0;
  bit run = 1'b0;

  task automatic chk(input string nm, input int c, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", nm, c, act, exp);
    end
  endtask

  // CRC as the remainder of (message * x^16) divided by 0x11021.
  function automatic logic [15:0] crc_buf();
    logic [16:0] r;
    r = '0;
    for (int k = 0; k < clen + 16; k++) begin
      r = {r[15:0], (k < clen) ? cbuf[k] : 1'b0};
      if (r[16]) r = r ^ 17'h11021;
    end
    return r[15:0];
  endfunction

  task automatic put(input logic st, input logic ab, input logic [7:0] q1, input logic [7:0] q2,
                     input logic nv, input logic [15:0] nd, input logic nb, input logic ndn);
    s_start[p] = st;  s_abort[p] = ab;  s_rst[p] = 1'b0;
    s_q1[p] = q1;     s_q2[p] = q2;
    s_len[p] = cur_len; s_to[p] = cur_to;
    e_valid[p+1] = nv; e_data[p+1] = nd; e_busy[p+1] = nb;
    e_done[p+1] = ndn; e_err[p+1] = m_err;
    p++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) put(1'b0, 1'b0, 8'($urandom), 8'($urandom), 1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic add_pin(input int c, input int k, input logic [15:0] v);
    pin_c[npin] = c; pin_k[npin] = k; pin_v[npin] = v; npin++;
  endtask

  task automatic bad_start(input int len);
    cur_len = 10'(len);
    m_err = 4'b1000;
    put(1'b1, 1'b0, 8'($urandom), 8'($urandom), 1'b0, 16'h0, 1'b0, 1'b1);
  endtask

  task automatic block(input int len, input int gap, input int to, input bit fixed,
                       input int flipw, input logic [7:0] endb, input int abort_w,
                       input int rst_w, input bit stray);
    int          nw;
    logic [15:0] cr [8];
    logic [15:0] cf [8];
    logic [7:0]  a, b;
    logic        st, crcerr;
    cur_len = 10'(len);
    cur_to  = 24'(to);
    m_err   = 4'b0;
    nw      = len / 2;
    if (!fixed) for (int k = 0; k < len; k++) pay[k] = 8'($urandom);
    for (int i = 0; i < 8; i++) begin
      clen = 0;
      for (int w = 0; w < nw; w++) begin cbuf[clen] = pay[2*w][i]; clen++; end
      cr[i] = crc_buf();
      clen = 0;
      for (int w = 0; w < nw; w++) begin cbuf[clen] = pay[2*w+1][i]; clen++; end
      cf[i] = crc_buf();
    end
    g_start_p = p;
    put(1'b1, 1'b0, 8'($urandom), 8'($urandom), 1'b0, 16'h0, 1'b1, 1'b0);
    for (int j = 0; j < gap; j++) begin
      a  = 8'($urandom_range(1, 255));
      st = stray && ($urandom_range(0, 3) == 0);
      if (to != 0 && j + 1 == to) begin
        m_err = 4'b0100;
        put(st, 1'b0, a, 8'($urandom), 1'b0, 16'h0, 1'b0, 1'b1);
        return;
      end
      put(st, 1'b0, a, 8'($urandom), 1'b0, 16'h0, 1'b1, 1'b0);
    end
    put(1'b0, 1'b0, 8'h00, 8'($urandom), 1'b0, 16'h0, 1'b1, 1'b0);
    g_word_p = p + 1;
    for (int w = 0; w < nw; w++) begin
      a = pay[2*w];
      b = pay[2*w+1];
      if (w == flipw) b = b ^ 8'h08;
      if (w == abort_w) begin
        put(1'b0, 1'b1, a, b, 1'b0, 16'h0, 1'b0, 1'b0);
        return;
      end
      if (w == rst_w) begin
        e_valid[p] = 1'b0; e_busy[p] = 1'b0; e_done[p] = 1'b0; e_err[p] = 4'b0;
        m_err = 4'b0;
        put(1'b0, 1'b0, a, b, 1'b0, 16'h0, 1'b0, 1'b0);
        s_rst[p-1] = 1'b1;
        return;
      end
      put(1'b0, 1'b0, a, b, 1'b1, {b, a}, 1'b1, 1'b0);
    end
    for (int t = 0; t < 16; t++) begin
      for (int i = 0; i < 8; i++) begin a[i] = cr[i][15-t]; b[i] = cf[i][15-t]; end
      put(1'b0, 1'b0, a, b, 1'b0, 16'h0, 1'b1, 1'b0);
    end
    crcerr = CRC_ON && (flipw >= 0) && (flipw < nw);
    m_err  = {2'b00, endb != 8'hFF, crcerr};
    put(1'b0, 1'b0, endb, 8'($urandom), 1'b0, 16'h0, 1'b0, 1'b1);
  endtask

  // Single compare process: every output, every cycle of the plan.
  always @(negedge clock) begin
    if (run) begin
      chk("out_valid",   cur, 16'(out_valid),   16'(e_valid[cur]));
      chk("busy",        cur, 16'(busy),        16'(e_busy[cur]));
      chk("done",        cur, 16'(done),        16'(e_done[cur]));
      chk("err_crc",     cur, 16'(err_crc),     16'(e_err[cur][0]));
      chk("err_end",     cur, 16'(err_end),     16'(e_err[cur][1]));
      chk("err_timeout", cur, 16'(err_timeout), 16'(e_err[cur][2]));
      chk("err_param",   cur, 16'(err_param),   16'(e_err[cur][3]));
      if (e_valid[cur]) chk("out_data", cur, out_data, e_data[cur]);
      for (int k = 0; k < npin; k++) begin
        if (pin_c[k] == cur) begin
          if (pin_k[k] == 0) chk("pin_data", cur, out_data, pin_v[k]);
          else               chk("pin_done", cur, 16'(done), pin_v[k]);
        end
      end
    end
  end

  initial begin
    int ln, gp, tv, fw;
    logic [7:0] eb;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; block_len = 10'd0; timeout_cycles = 24'd0;
    iddr_q1 = 8'h00; iddr_q2 = 8'h00;
    for (int n = 0; n < MAXC; n++) begin
      s_start[n] = 1'b0; s_abort[n] = 1'b0; s_rst[n] = 1'b0; s_q1[n] = 8'h01; s_q2[n] = 8'h00;
      s_len[n] = 10'd2; s_to[n] = 24'd0; e_valid[n] = 1'b0; e_busy[n] = 1'b0;
      e_done[n] = 1'b0; e_data[n] = 16'h0; e_err[n] = 4'b0;
    end

    // Pin the reference CRC: CRC16/XMODEM of "123456789" is 0x31C3.
    clen = 0;
    for (int c = 0; c < 9; c++) begin
      eb = 8'(8'h31 + c);
      for (int k = 7; k >= 0; k--) begin cbuf[clen] = eb[k]; clen++; end
    end
    chk("model_crc", -1, crc_buf(), 16'h31C3);

    idle(4);
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44;
    block(4, 3, 0, 1'b1, -1, 8'hFF, -1, -1, 1'b0);
    add_pin(g_word_p, 0, 16'h2211);
    add_pin(g_word_p + 1, 0, 16'h4433);
    idle(2);
    block(4, 3, 0, 1'b1, 0, 8'hFF, -1, -1, 1'b0);
    add_pin(g_word_p, 0, 16'h2A11);
    idle(2);
    block(8, 10, 5, 1'b0, -1, 8'hFF, -1, -1, 1'b0);
    add_pin(g_start_p + 1 + 4, 1, 16'h0);
    add_pin(g_start_p + 1 + 5, 1, 16'h1);
    idle(1);
    block(6, 2, 0, 1'b0, -1, 8'hFE, -1, -1, 1'b0);
    idle(2);
    bad_start(3);
    idle(1);
    bad_start(0);
    bad_start(514);
    idle(1);
    cur_len = 10'd8;
    put(1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 16'h0, 1'b0, 1'b0);
    idle(2);
    block(512, 1, 0, 1'b0, -1, 8'hFF, -1, -1, 1'b0);
    idle(1);
    block(512, 2, 0, 1'b0, -1, 8'hFF, 10, -1, 1'b0);
    idle(2);
    block(8, 1, 0, 1'b0, -1, 8'hFF, -1, -1, 1'b0);
    idle(1);
    block(512, 0, 0, 1'b0, -1, 8'hFF, -1, 20, 1'b0);
    idle(1);
    block(6, 1, 0, 1'b0, -1, 8'hFF, -1, -1, 1'b0);
    block(4, 3, 1, 1'b0, -1, 8'hFF, -1, -1, 1'b0);
    block(2, 0, 0, 1'b0, -1, 8'hFF, -1, -1, 1'b0);
    for (int r = 0; r < 20; r++) begin
      ln = 2 * int'($urandom_range(1, 40));
      gp = int'($urandom_range(0, 6));
      tv = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 8));
      fw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, ln / 2 - 1)) : -1;
      eb = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 254)) : 8'hFF;
      block(ln, gp, tv, 1'b0, fw, eb, -1, -1, 1'b1);
      idle(int'($urandom_range(0, 3)));
    end
    idle(3);

    repeat (3) @(posedge clock);
    #1;
    chk("rst_out_data",  -1, out_data,         16'h0);
    chk("rst_out_valid", -1, 16'(out_valid),   16'h0);
    chk("rst_busy",      -1, 16'(busy),        16'h0);
    chk("rst_done",      -1, 16'(done),        16'h0);
    chk("rst_errs",      -1, 16'({err_crc, err_end, err_timeout, err_param}), 16'h0);
    @(negedge clock);
    reset_n = 1'b1;

    for (int n = 0; n <= p; n++) begin
      @(posedge clock);
      #1;
      cur = n;
      run = 1'b1;
      if (s_rst[n]) begin
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
      end
      start = s_start[n]; abort = s_abort[n];
      iddr_q1 = s_q1[n];  iddr_q2 = s_q2[n];
      block_len = s_len[n]; timeout_cycles = s_to[n];
    end
    @(posedge clock);
    #1;
    run = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
